// File: rtl/serial_mult_ctrl_pkg.sv
// Shared definitions for the serial shift-add multiplier: the default operand
// width and the controller state enumeration.
package serial_mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_mult_ctrl_if.sv
// Operand/product handshake bundle for serial_mult_ctrl.
// The master drives the operands and out_ready; the slave (the multiplier)
// drives in_ready, out_valid, product and busy.
interface serial_mult_ctrl_if
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/serial_mult_ctrl_fa_bit.sv
// Gate-level 1-bit full adder. The multiplier owns exactly one of these and
// time-shares it across every bit position and every iteration.
module fa_bit (
  input  wire i_a,
  input  wire i_b,
  input  wire i_cin,
  output wire o_s,
  output wire o_cout
);

  wire w_ab_x;
  wire w_ab_a;
  wire w_c_a;

  xor g_x1 (w_ab_x, i_a, i_b);
  xor g_x2 (o_s, w_ab_x, i_cin);
  and g_a1 (w_ab_a, i_a, i_b);
  and g_a2 (w_c_a, w_ab_x, i_cin);
  or  g_o1 (o_cout, w_ab_a, w_c_a);

endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-add unsigned multiplier controller.
// Each partial-product addition ripples through one shared full adder, one bit
// per cycle (ADD), followed by a one-cycle right shift of {C,A,Q} (SHIFT).
// Optional macro SERIAL_MULT_SKIP_ZERO_EN: when defined, ADD is bypassed for
// zero multiplier bits, making latency data dependent.
module serial_mult_ctrl
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_mult_ctrl_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_c;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_iter_cnt;

  logic w_fa_b;
  logic w_sum;
  logic w_cout;
  logic w_accept;
  logic w_skip_accept;
  logic w_skip_shift;

  // Addend bit is M[0] gated by the current multiplier bit, so a zero
  // multiplier bit adds zero while still walking all positions.
  assign w_fa_b = r_m[0] & r_q[0];

  fa_bit u_fa (
    .i_a    (r_a[0]),
    .i_b    (w_fa_b),
    .i_cin  (r_c),
    .o_s    (w_sum),
    .o_cout (w_cout)
  );

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);

`ifdef SERIAL_MULT_SKIP_ZERO_EN
  // Next multiplier LSB: mplier[0] on load, Q[1] after a shift.
  assign w_skip_accept = ~bus.mplier[0];
  assign w_skip_shift  = ~r_q[1];
`else
  assign w_skip_accept = 1'b0;
  assign w_skip_shift  = 1'b0;
`endif

  // Controller and datapath: load, serial add through the shared adder, shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_m        <= '0;
      r_a        <= '0;
      r_q        <= '0;
      r_c        <= 1'b0;
      r_bit_cnt  <= '0;
      r_iter_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_m        <= bus.mcand;
            r_q        <= bus.mplier;
            r_a        <= '0;
            r_c        <= 1'b0;
            r_bit_cnt  <= '0;
            r_iter_cnt <= '0;
            r_state    <= w_skip_accept ? ST_SHIFT : ST_ADD;
          end
        end
        ST_ADD: begin
          // Sum enters at the MSB; after WIDTH rotations A holds the full
          // sum in order and M is back to its original alignment.
          r_a       <= {w_sum, r_a[WIDTH-1:1]};
          r_m       <= {r_m[0], r_m[WIDTH-1:1]};
          r_c       <= w_cout;
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (r_bit_cnt == LAST) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The shift also clears C for the next addition pass.
          {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[WIDTH-1:1]};
          r_iter_cnt      <= r_iter_cnt + CW'(1);
          r_bit_cnt       <= '0;
          if (r_iter_cnt == LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= w_skip_shift ? ST_SHIFT : ST_ADD;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_ADD) || (r_state == ST_SHIFT);
  assign bus.product   = {r_a, r_q};

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Scoreboard testbench for serial_mult_ctrl (WIDTH=4).
// The driver pushes the expected product and latency at each accept; a monitor
// on the falling edge checks every cycle the product is presented.
module tb_serial_mult_ctrl;
  import serial_mult_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int exp;
    int lat;
    int acc;
    int a;
    int b;
  } sb_t;

  sb_t sb[$];

  serial_mult_ctrl_if #(.WIDTH(W)) bus ();

  serial_mult_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SERIAL_MULT_SKIP_ZERO_EN
    return W + W * $countones(b);
`else
    return W * (W + 1);
`endif
  endfunction

  // Present one operand pair; push the expectation once it is accepted.
  task automatic send(input int a, input int b, input int exp, input bit push);
    int n;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    n  = 0;
    av = W'(a);
    bv = W'(b);
    while (!bus.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    bus.mcand    = av;
    bus.mplier   = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{exp, exp_lat(bv), cyc, a, b});
    bus.in_valid = 1'b0;
    bus.mcand    = ~av;
    bus.mplier   = ~bv;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=pending%0d required=pending0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: latency at the rising out_valid, product every presented cycle.
  initial begin
    bit v_prev;
    v_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        v_prev = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            if (!v_prev) begin
              total++;
              bad++;
              $display("FAIL unexpected_output actual=product%0d required=no_output", bus.product);
            end
          end else begin
            if (!v_prev) chk("latency", cyc - sb[0].acc, sb[0].lat);
            chk("product", int'(bus.product), sb[0].exp);
            if (bus.out_ready) begin
              $display("txn %0d*%0d product=%0d expected=%0d latency=%0d",
                       sb[0].a, sb[0].b, bus.product, sb[0].exp, cyc - sb[0].acc);
              void'(sb.pop_front());
            end
          end
        end
        v_prev = bus.out_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  int a_v[8] = '{0, 15, 1, 9, 5, 10, 12, 7};
  int b_v[8] = '{9, 15, 15, 0, 10, 5, 3, 7};
  int p_v[8] = '{0, 225, 15, 0, 50, 50, 36, 49};

  initial begin
    bus.in_valid  = 1'b0;
    bus.mcand     = '0;
    bus.mplier    = '0;
    bus.out_ready = 1'b1;

    // Reset state, while asserted and after release
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_product", int'(bus.product), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", int'(bus.in_ready), 1);
    chk("idle_out_valid", int'(bus.out_valid), 0);
    chk("idle_product", int'(bus.product), 0);

    // Basic operation
    send(11, 13, 143, 1'b1);
    chk("op_busy", int'(bus.busy), 1);
    chk("op_in_ready", int'(bus.in_ready), 0);
    wait_done();

    // Corners and assorted patterns
    for (int i = 0; i < 8; i++) begin
      send(a_v[i], b_v[i], p_v[i], 1'b1);
      wait_done();
    end

    // Backpressure: hold DONE, attempt an ignored operand pair
    bus.out_ready = 1'b0;
    send(9, 7, 63, 1'b1);
    for (int n = 0; n < 300 && !bus.out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid", int'(bus.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_busy", int'(bus.busy), 0);
      bus.mcand    = 4'd2;
      bus.mplier   = 4'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();
    chk("bp_idle_after", int'(bus.in_ready), 1);

    // Reset in the middle of an operation: no output may appear
    send(6, 7, 42, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_product", int'(bus.product), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    send(3, 5, 15, 1'b1);
    wait_done();

`ifdef SERIAL_MULT_SKIP_ZERO_EN
    send(6, 8, 48, 1'b1);
    wait_done();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(a, b, a * b, 1'b1);
        wait_done();
      end
    end
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mult_ctrl.md
SERIAL_MULT_CTRL -- requirements
Module: serial_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block idle, can accept operands.
REQ-006 mcand  input  WIDTH  multiplicand, unsigned.
REQ-007 mplier  input  WIDTH  multiplier, unsigned.
REQ-008 out_valid  output  1  product valid.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 product  output  2*WIDTH  unsigned product.
REQ-011 busy  output  1  high in ADD or SHIFT state.

Function
REQ-012 The block SHALL compute mcand*mplier by shift-add, using exactly one 1-bit full-adder instance shared across all bit positions and iterations.
REQ-013 Registers: M (WIDTH), A (WIDTH), Q (WIDTH), carry flip-flop C, bit counter (log2 WIDTH+1), iteration counter (log2 WIDTH+1).
REQ-014 States: IDLE, ADD, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&in_ready, M<=mcand, Q<=mplier, A<=0, C<=0, both counters<=0, go to ADD.
REQ-016 ADD: each cycle, adder inputs A[0], (M[0]&Q[0]), C; A<=rotate-right with sum into MSB; M<=rotate-right; C<=carry-out; after WIDTH cycles go to SHIFT.
REQ-017 At ADD exit, A SHALL equal the WIDTH-bit sum and M its original value; C holds the carry-out.
REQ-018 SHIFT (1 cycle): {C,A,Q}<={1'b0,C,A,Q[WIDTH-1:1]}; increment iteration counter; after the WIDTH-th SHIFT go to DONE, else ADD with bit counter and C cleared.
REQ-019 Without SKIP_ZERO_EN, latency from accept edge to out_valid high SHALL be WIDTH*(WIDTH+1) cycles (20 for WIDTH=4), independent of data.
REQ-020 DONE: product={A,Q}; held stable until out_ready; on out_valid&out_ready go to IDLE.
REQ-021 in_valid outside IDLE SHALL be ignored; operands are not buffered.
REQ-022 mcand/mplier changes after acceptance SHALL NOT affect the result.
REQ-023 Zero and all-ones operands SHALL give exact results (e.g. 15*15=225 at WIDTH=4).

Reset
REQ-024 rst high SHALL force state IDLE, A, Q, M, C, counters to 0; in_ready=1, out_valid=0, busy=0, product=0.
REQ-025 rst asserted mid-ADD/SHIFT/DONE SHALL abort the operation with no out_valid pulse; first accept after release starts a fresh operation.

Configuration
REQ-026 Macro SERIAL_MULT_SKIP_ZERO_EN: when defined, at ADD entry with Q[0]==0 the block SHALL skip ADD and go straight to SHIFT (C=0), so each zero multiplier bit costs 1 cycle; latency = WIDTH + WIDTH*popcount(mplier).
REQ-027 Without the macro, ADD always runs WIDTH cycles (adding zero when Q[0]==0); fixed latency per REQ-019.

Structure
REQ-028 Shared package serial_mult_pkg SHALL hold the state enumeration type and the default WIDTH constant.
REQ-029 One sub-module, fa_bit (A, B, Cin -> S, Cout, gate-level), SHALL be instantiated exactly once; no other arithmetic operator on datapath registers.

Verification
REQ-030 Reset: rst pulse -> in_ready=1, out_valid=0, product=0 before any stimulus.
REQ-031 Basic: WIDTH=4, 11*13, out_ready=1 -> product=143, out_valid exactly 20 cycles after accept (macro off).
REQ-032 Corners: 0*9 -> 0; 15*15 -> 225; 1*15 -> 15; all at fixed 20-cycle latency.
REQ-033 Backpressure: out_ready=0 for 5 cycles after DONE -> product stable, in_ready=0; new in_valid ignored; accept on out_ready.
REQ-034 Mid-op reset: rst at cycle 7 of 6*7 -> no out_valid; following 3*5 -> 15.
REQ-035 Macro on: 6*8 (mplier=1000b) -> 48 at latency 4+4*1=8; exhaustive 4-bit sweep matches reference model.
